// File: rtl/slv_spi.sv
// SPI responder: oversamples sclk/mosi/cs_n in the clk domain, deserialises MSB-first frames, returns a preloaded word on miso.
// Optional build macro SLV_SPI_FRAME_ERR_EN adds the frame_err pulse output (mid-frame abort or start-of-frame underrun).
module slv_spi #(
  parameter int BUS      = 4,
  parameter int SYNC_STG = 2
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic [1:0]     mode,
  input  logic [BUS-1:0] tx_byte,
  input  logic           tx_vld,
  output logic           tx_rdy,
  output logic [BUS-1:0] rx_byte,
  output logic           rx_vld,
  input  logic           sclk,
  input  logic           cs_n,
  input  logic           mosi,
  output logic           miso,
`ifdef SLV_SPI_FRAME_ERR_EN
  output logic           frame_err,
`endif
  output logic           dbg_state_o
);

  localparam int CW = (BUS > 2) ? $clog2(BUS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BUS - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  // tx handshake: tx_vld always writes the shadow; tx_rdy only reports that it is empty.

  logic [SYNC_STG-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                sclk_prev_q, cs_prev_q;

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BUS-1:0] rx_shift_q, rx_shift_d;
  logic [BUS-1:0] tx_shift_q, tx_shift_d;
  logic [BUS-1:0] shadow_q, shadow_d;
  logic           full_q, full_d;
  logic           first_q, first_d;
  logic           reload_q, reload_d;
  logic           done_q, done_d;
  logic [BUS-1:0] rx_byte_q, rx_byte_d;
  logic           rx_vld_q, rx_vld_d;
  logic           err_q, err_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic lead_edge, trail_edge, samp_edge, shft_edge;
  logic [BUS-1:0] tx_load;
  logic           underrun;

  // Sync chains reset to 0 so a select already low at reset release never starts a frame.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STG-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STG-1];
  assign cs_s      = cs_sync_q[SYNC_STG-1];
  assign mosi_s    = mosi_sync_q[SYNC_STG-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  assign lead_edge  = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge = mode_q[1] ? sclk_rise : sclk_fall;
  assign samp_edge  = mode_q[0] ? trail_edge : lead_edge;
  assign shft_edge  = mode_q[0] ? lead_edge : trail_edge;

  // A word offered in the load cycle bypasses the shadow; an empty shadow shifts out zeros.
  assign tx_load  = tx_vld ? tx_byte : (full_q ? shadow_q : '0);
  assign underrun = ~tx_vld & ~full_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      shadow_q   <= '0;
      full_q     <= 1'b0;
      first_q    <= 1'b0;
      reload_q   <= 1'b0;
      done_q     <= 1'b0;
      rx_byte_q  <= '0;
      rx_vld_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      shadow_q   <= shadow_d;
      full_q     <= full_d;
      first_q    <= first_d;
      reload_q   <= reload_d;
      done_q     <= done_d;
      rx_byte_q  <= rx_byte_d;
      rx_vld_q   <= rx_vld_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    shadow_d   = shadow_q;
    full_d     = full_q;
    first_d    = first_q;
    reload_d   = reload_q;
    rx_byte_d  = rx_byte_q;
    done_d     = 1'b0;
    rx_vld_d   = 1'b0;
    err_d      = 1'b0;

    if (done_q) begin
      rx_byte_d = rx_shift_q;
      rx_vld_d  = 1'b1;
    end
    if (tx_vld) begin
      shadow_d = tx_byte;
      full_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          mode_d     = mode;
          bit_cnt_d  = '0;
          tx_shift_d = tx_load;
          full_d     = 1'b0;
          first_d    = 1'b1;
          reload_d   = 1'b0;
          err_d      = underrun;
        end
      end
      ACTIVE: begin
        if (samp_edge) begin
          rx_shift_d = {rx_shift_q[BUS-2:0], mosi_s};
          if (bit_cnt_q == LAST) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            reload_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        // With CPHA=1 the first leading edge only ends the MSB setup window.
        if (shft_edge) begin
          first_d = 1'b0;
          if (reload_q) begin
            tx_shift_d = tx_load;
            full_d     = 1'b0;
            reload_d   = 1'b0;
          end else if (!(first_q && mode_q[0])) begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          if (bit_cnt_q != '0 && !(samp_edge && bit_cnt_q == LAST)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_rdy      = ~full_q;
  assign rx_byte     = rx_byte_q;
  assign rx_vld      = rx_vld_q;
  assign miso        = (state_q == ACTIVE) ? tx_shift_q[BUS-1] : 1'b0;
  assign dbg_state_o = state_q;

`ifdef SLV_SPI_FRAME_ERR_EN
  assign frame_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_slv_spi.sv
// Directed bench for slv_spi: bench-side SPI master, received-word scoreboard and pulse counters.
module tb_slv_spi;
  localparam int BUS = 4;
  localparam int H   = 8;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic [BUS-1:0] tx_byte = '0;
  logic           tx_vld = 1'b0;
  logic           tx_rdy;
  logic [BUS-1:0] rx_byte;
  logic           rx_vld;
  logic           sclk = 1'b0;
  logic           cs_n = 1'b1;
  logic           mosi = 1'b0;
  logic           miso;
  logic           dbg_state;
`ifdef SLV_SPI_FRAME_ERR_EN
  logic           frame_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int vld_cnt  = 0;
  int err_cnt  = 0;
  logic [BUS-1:0] exp_q[$];

  slv_spi #(.BUS(BUS), .SYNC_STG(2)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .mode       (mode),
    .tx_byte    (tx_byte),
    .tx_vld     (tx_vld),
    .tx_rdy     (tx_rdy),
    .rx_byte    (rx_byte),
    .rx_vld     (rx_vld),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
`ifdef SLV_SPI_FRAME_ERR_EN
    .frame_err  (frame_err),
`endif
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every rx_vld pulse must match the next expected word
  always @(negedge clk) begin
    if (rx_vld) begin
      vld_cnt++;
      if (exp_q.size() > 0) check("rx_word", 32'(rx_byte), 32'(exp_q.pop_front()));
      else check("rx_unexpected_vld", 32'(rx_vld), 32'd0);
    end
  end

`ifdef SLV_SPI_FRAME_ERR_EN
  always @(negedge clk) if (frame_err) err_cnt++;
`endif

  // Driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [BUS-1:0] v);
    @(negedge clk);
    tx_byte = v;
    tx_vld  = 1'b1;
    @(negedge clk);
    tx_vld  = 1'b0;
  endtask

  task automatic cs_low(input logic [1:0] m);
    mode = m;
    sclk = m[1];
    wait_clk(H);
    cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    wait_clk(H);
    cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic frame(input logic [BUS-1:0] tx, output logic [BUS-1:0] rx, input int nbits);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!mode[0]) begin
        mosi = tx[BUS-1-i];
        wait_clk(H);
        sclk = ~mode[1];
        rx[BUS-1-i] = miso;
        wait_clk(H);
        sclk = mode[1];
      end else begin
        sclk = ~mode[1];
        mosi = tx[BUS-1-i];
        wait_clk(H);
        sclk = mode[1];
        rx[BUS-1-i] = miso;
        wait_clk(H);
      end
    end
  endtask

  logic [BUS-1:0] r1, r2;
  int v0, e0;

  initial begin
    // reset state
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_rx_byte", 32'(rx_byte), 32'd0);
    check("rst_rx_vld", 32'(rx_vld), 32'd0);
    check("rst_tx_rdy", 32'(tx_rdy), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef SLV_SPI_FRAME_ERR_EN
    check("rst_frame_err", 32'(frame_err), 32'd0);
`endif
    arst_n = 1'b1;
    wait_clk(4);

    // mode 0: shadow A, master sends 5
    v0 = vld_cnt; e0 = err_cnt;
    tx_write(4'hA);
    check("m0_tx_rdy_full", 32'(tx_rdy), 32'd0);
    exp_q.push_back(4'h5);
    cs_low(2'd0);
    check("m0_active", 32'(dbg_state), 32'd1);
    check("m0_tx_rdy_consumed", 32'(tx_rdy), 32'd1);
    frame(4'h5, r1, BUS);
    cs_high();
    check("m0_miso_word", 32'(r1), 32'hA);
    check("m0_rx_byte", 32'(rx_byte), 32'h5);
    check("m0_vld_pulses", 32'(vld_cnt - v0), 32'd1);
    check("m0_idle", 32'(dbg_state), 32'd0);
`ifdef SLV_SPI_FRAME_ERR_EN
    check("m0_no_err", 32'(err_cnt - e0), 32'd0);
`endif

    // modes 1..3: shadow 3, master sends C
    for (int m = 1; m < 4; m++) begin
      v0 = vld_cnt;
      tx_write(4'h3);
      exp_q.push_back(4'hC);
      cs_low(2'(m));
      frame(4'hC, r1, BUS);
      cs_high();
      check($sformatf("mode%0d_miso_word", m), 32'(r1), 32'h3);
      check($sformatf("mode%0d_rx_byte", m), 32'(rx_byte), 32'hC);
      check($sformatf("mode%0d_vld_pulses", m), 32'(vld_cnt - v0), 32'd1);
    end

    // back-to-back frames under one select
    v0 = vld_cnt;
    tx_write(4'h1);
    exp_q.push_back(4'h9);
    exp_q.push_back(4'h6);
    cs_low(2'd0);
    tx_write(4'h2);
    frame(4'h9, r1, BUS);
    frame(4'h6, r2, BUS);
    cs_high();
    check("b2b_miso_first", 32'(r1), 32'h1);
    check("b2b_miso_second", 32'(r2), 32'h2);
    check("b2b_vld_pulses", 32'(vld_cnt - v0), 32'd2);
    check("b2b_rx_byte", 32'(rx_byte), 32'h6);

    // set rx_byte to 5, then abort after 2 bits of F
    tx_write(4'h0);
    exp_q.push_back(4'h5);
    cs_low(2'd0);
    frame(4'h5, r1, BUS);
    cs_high();
    v0 = vld_cnt; e0 = err_cnt;
    tx_write(4'h0);
    cs_low(2'd0);
    frame(4'hF, r1, 2);
    cs_high();
    check("abort_no_vld", 32'(vld_cnt - v0), 32'd0);
    check("abort_rx_byte_held", 32'(rx_byte), 32'h5);
    check("abort_idle", 32'(dbg_state), 32'd0);
    check("abort_miso_low", 32'(miso), 32'd0);
`ifdef SLV_SPI_FRAME_ERR_EN
    check("abort_frame_err", 32'(err_cnt - e0), 32'd1);
`endif

    // underrun: no tx_vld since the last frame
    v0 = vld_cnt; e0 = err_cnt;
    check("under_tx_rdy_before", 32'(tx_rdy), 32'd1);
    exp_q.push_back(4'hA);
    cs_low(2'd0);
    frame(4'hA, r1, BUS);
    cs_high();
    check("under_miso_zero", 32'(r1), 32'h0);
    check("under_tx_rdy_after", 32'(tx_rdy), 32'd1);
    check("under_rx_byte", 32'(rx_byte), 32'hA);
`ifdef SLV_SPI_FRAME_ERR_EN
    check("under_frame_err", 32'(err_cnt - e0), 32'd1);
`endif

    // reset mid-frame, then a clean 7 frame
    v0 = vld_cnt;
    tx_write(4'h5);
    cs_low(2'd0);
    frame(4'hF, r1, 2);
    arst_n = 1'b0;
    wait_clk(3);
    check("arst_rx_byte", 32'(rx_byte), 32'd0);
    check("arst_miso", 32'(miso), 32'd0);
    check("arst_tx_rdy", 32'(tx_rdy), 32'd1);
    check("arst_rx_vld", 32'(rx_vld), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    arst_n = 1'b1;
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(12);
    check("arst_no_partial_vld", 32'(vld_cnt - v0), 32'd0);
    check("arst_still_idle", 32'(dbg_state), 32'd0);
    v0 = vld_cnt;
    tx_write(4'h3);
    exp_q.push_back(4'h7);
    cs_low(2'd0);
    frame(4'h7, r1, BUS);
    cs_high();
    check("post_rst_rx_byte", 32'(rx_byte), 32'h7);
    check("post_rst_miso_word", 32'(r1), 32'h3);
    check("post_rst_vld_pulses", 32'(vld_cnt - v0), 32'd1);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
